// File: rtl/ssp_uart_lite2_pkg.sv
// ============================================================================
// ssp_uart_lite2_pkg : register map, bit indices and FSM encodings
// Rev 1.0
// ============================================================================
`default_nettype none

package ssp_uart_lite2_pkg;

  localparam logic [2:0] RA_TXD    = 3'd0;
  localparam logic [2:0] RA_RXD    = 3'd1;
  localparam logic [2:0] RA_CTRL   = 3'd2;
  localparam logic [2:0] RA_BAUD   = 3'd3;
  localparam logic [2:0] RA_STATUS = 3'd4;

  localparam int CTRL_TXEN    = 0;
  localparam int CTRL_RXEN    = 1;
  localparam int CTRL_IE_RXNE = 2;
  localparam int CTRL_IE_TXE  = 3;
  localparam int CTRL_IE_ERR  = 4;
  localparam int CTRL_PEN     = 5;
  localparam int CTRL_PODD    = 6;
  localparam int CTRL_CTSEN   = 7;

  localparam int ST_TXFULL  = 0;
  localparam int ST_TXEMPTY = 1;
  localparam int ST_RXNE    = 2;
  localparam int ST_RXFULL  = 3;
  localparam int ST_RXOVR   = 4;
  localparam int ST_TXOVR   = 5;
  localparam int ST_FERR    = 6;
  localparam int ST_PERR    = 7;
  localparam int ST_TXIDLE  = 8;
  localparam int ST_RXIDLE  = 9;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
    TX_PARITY = 3'd3,
    TX_STOP   = 3'd4
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE   = 3'd0,
    RX_START  = 3'd1,
    RX_DATA   = 3'd2,
    RX_PARITY = 3'd3,
    RX_STOP   = 3'd4
  } rx_state_e;

  // Divisor values below 2 would not leave room for a half-bit sample point.
  function automatic logic [11:0] eff_baud(input logic [11:0] b);
    return (b < 12'd2) ? 12'd2 : b;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ssp_uart_lite2_fifo.sv
// ============================================================================
// ssp_uart_lite2_fifo : 2^AW-entry FIFO, AW=0 gives a single holding register
// Rev 1.0
// ============================================================================
`default_nettype none

module ssp_uart_lite2_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          pop_i,
  output logic [W-1:0]  rdata_o,
  output logic [AW:0]   count_o
);

  generate
    if (AW == 0) begin : g_reg
      logic [W-1:0] data_q;
      logic         valid_q;
      logic         pop_ok;
      logic         push_ok;

      assign pop_ok  = pop_i & valid_q;
      assign push_ok = push_i & (~valid_q | pop_ok);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) valid_q <= 1'b0;
        else       valid_q <= push_ok | (valid_q & ~pop_ok);
      end

      always_ff @(posedge clk_i) begin
        if (push_ok) data_q <= wdata_i;
      end

      assign rdata_o = data_q;
      assign count_o = valid_q;
    end else begin : g_ram
      localparam int DEPTH = 1 << AW;
      logic [W-1:0] mem_q [DEPTH];
      logic [AW:0]  wptr_q, rptr_q;
      logic         empty, full, pop_ok, push_ok;

      // Extra MSB on the pointers separates full from empty.
      assign empty   = (wptr_q == rptr_q);
      assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      assign pop_ok  = pop_i & ~empty;
      assign push_ok = push_i & (~full | pop_ok);

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          wptr_q <= '0;
          rptr_q <= '0;
        end else begin
          if (push_ok) wptr_q <= wptr_q + 1'b1;
          if (pop_ok)  rptr_q <= rptr_q + 1'b1;
        end
      end

      always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
      end

      assign rdata_o = mem_q[rptr_q[AW-1:0]];
      assign count_o = wptr_q - rptr_q;
    end
  endgenerate

endmodule

`default_nettype wire

// File: rtl/ssp_uart_lite2.sv
// ============================================================================
// ssp_uart_lite2 : SSP-slave UART with FIFOs; parity via SSP_UART_LITE2_PARITY_EN
// Rev 1.0
// ============================================================================
`default_nettype none

module ssp_uart_lite2
  import ssp_uart_lite2_pkg::*;
#(
  parameter int          pDataBits = 8,
  parameter int          pFifoAw   = 4,
  parameter logic [11:0] pBaudRst  = 12'd433
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        SSP_SSEL,
  input  logic [2:0]  SSP_RA,
  input  logic        SSP_WnR,
  input  logic        SSP_En,
  input  logic        SSP_EOC,
  input  logic [11:0] SSP_DI,
  output logic [11:0] SSP_DO,
  input  logic        RxD_232,
  input  logic        xCTS,
  output logic        TxD_232,
  output logic        xRTS,
  output logic        IRQ,
  output logic        TxIdle,
  output logic        RxIdle
);

  localparam int DEPTH = 1 << pFifoAw;
  localparam int RXW   = pDataBits + 2;

`ifdef SSP_UART_LITE2_PARITY_EN
  localparam logic [7:0] CTRL_MASK = 8'hFF;
`else
  localparam logic [7:0] CTRL_MASK = ~(8'(1 << CTRL_PEN) | 8'(1 << CTRL_PODD));
`endif

  logic [7:0]  ctrl_q;
  logic [11:0] baud_q, do_q, rd_data, status, baud_eff;
  logic        tx_ovr_q, rx_ovr_q, ferr_q, perr_st_q;
  logic        wr, rd_eoc, pen, podd;
  logic        tx_push, tx_pop, tx_empty, tx_full;
  logic        rx_push, rx_pop, rx_empty, rx_full, rx_room;
  logic [pDataBits-1:0] tx_rdata;
  logic [RXW-1:0]       rx_rdata, rx_word;
  logic [pFifoAw:0]     tx_count, rx_count;

  assign wr       = SSP_SSEL & SSP_EOC & SSP_WnR;
  assign rd_eoc   = SSP_SSEL & SSP_EOC & ~SSP_WnR;
  assign baud_eff = eff_baud(baud_q);

`ifdef SSP_UART_LITE2_PARITY_EN
  assign pen  = ctrl_q[CTRL_PEN];
  assign podd = ctrl_q[CTRL_PODD];
`else
  assign pen  = 1'b0;
  assign podd = 1'b0;
`endif

  assign tx_push  = wr & (SSP_RA == RA_TXD);
  assign rx_pop   = rd_eoc & (SSP_RA == RA_RXD) & ~rx_empty;
  assign tx_empty = (tx_count == '0);
  assign tx_full  = (int'(tx_count) == DEPTH);
  assign rx_empty = (rx_count == '0);
  assign rx_full  = (int'(rx_count) == DEPTH);

  ssp_uart_lite2_fifo #(.W(pDataBits), .AW(pFifoAw)) u_tx_fifo (
    .clk_i(Clk), .rst_i(Rst), .push_i(tx_push), .wdata_i(SSP_DI[pDataBits-1:0]),
    .pop_i(tx_pop), .rdata_o(tx_rdata), .count_o(tx_count)
  );

  ssp_uart_lite2_fifo #(.W(RXW), .AW(pFifoAw)) u_rx_fifo (
    .clk_i(Clk), .rst_i(Rst), .push_i(rx_push), .wdata_i(rx_word),
    .pop_i(rx_pop), .rdata_o(rx_rdata), .count_o(rx_count)
  );

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      ctrl_q    <= '0;
      baud_q    <= pBaudRst;
      do_q      <= '0;
      tx_ovr_q  <= 1'b0;
      rx_ovr_q  <= 1'b0;
      ferr_q    <= 1'b0;
      perr_st_q <= 1'b0;
    end else begin
      if (wr && SSP_RA == RA_CTRL) ctrl_q <= SSP_DI[7:0] & CTRL_MASK;
      if (wr && SSP_RA == RA_BAUD) baud_q <= SSP_DI;
      if (SSP_SSEL && SSP_En && !SSP_WnR) do_q <= rd_data;
      // A new error in the clearing cycle survives the clear.
      if (rd_eoc && SSP_RA == RA_STATUS) begin
        tx_ovr_q  <= 1'b0;
        rx_ovr_q  <= 1'b0;
        ferr_q    <= 1'b0;
        perr_st_q <= 1'b0;
      end
      if (tx_push & tx_full & ~tx_pop)    tx_ovr_q  <= 1'b1;
      if (rx_push & rx_full & ~rx_pop)    rx_ovr_q  <= 1'b1;
      if (rx_push & rx_word[pDataBits])   ferr_q    <= 1'b1;
      if (rx_push & rx_word[pDataBits+1]) perr_st_q <= 1'b1;
    end
  end

  always_comb begin
    status             = '0;
    status[ST_TXFULL]  = tx_full;
    status[ST_TXEMPTY] = tx_empty;
    status[ST_RXNE]    = ~rx_empty;
    status[ST_RXFULL]  = rx_full;
    status[ST_RXOVR]   = rx_ovr_q;
    status[ST_TXOVR]   = tx_ovr_q;
    status[ST_FERR]    = ferr_q;
    status[ST_PERR]    = perr_st_q;
    status[ST_TXIDLE]  = TxIdle;
    status[ST_RXIDLE]  = RxIdle;
  end

  always_comb begin
    rd_data = '0;
    case (SSP_RA)
      RA_RXD: begin
        if (!rx_empty) begin
          rd_data[pDataBits-1:0] = rx_rdata[pDataBits-1:0];
          rd_data[10]            = rx_rdata[pDataBits];
          rd_data[11]            = rx_rdata[pDataBits+1];
        end
      end
      RA_CTRL:   rd_data = {4'd0, ctrl_q};
      RA_BAUD:   rd_data = baud_q;
      RA_STATUS: rd_data = status;
      default:   rd_data = '0;
    endcase
  end

  // ---------------- transmitter ----------------
  tx_state_e            tx_state_q, tx_state_d;
  logic [11:0]          tx_cnt_q, tx_cnt_d;
  logic [pDataBits-1:0] tx_sh_q, tx_sh_d;
  logic [2:0]           tx_bit_q, tx_bit_d;
  logic                 tx_par_q, tx_par_d, txd_q, txd_d, tx_tick;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_sh_q    <= '0;
      tx_bit_q   <= '0;
      tx_par_q   <= 1'b0;
      txd_q      <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_sh_q    <= tx_sh_d;
      tx_bit_q   <= tx_bit_d;
      tx_par_q   <= tx_par_d;
      txd_q      <= txd_d;
    end
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_sh_d    = tx_sh_q;
    tx_bit_d   = tx_bit_q;
    tx_par_d   = tx_par_q;
    tx_pop     = 1'b0;
    tx_tick    = (tx_cnt_q == '0);
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_tick ? baud_eff : tx_cnt_q - 12'd1;
    case (tx_state_q)
      TX_IDLE: begin
        if (ctrl_q[CTRL_TXEN] && !tx_empty && (!ctrl_q[CTRL_CTSEN] || !xCTS)) begin
          tx_pop     = 1'b1;
          tx_sh_d    = tx_rdata;
          tx_par_d   = (^tx_rdata) ^ podd;
          tx_bit_d   = '0;
          tx_cnt_d   = baud_eff;
          tx_state_d = TX_START;
        end
      end
      TX_START:  if (tx_tick) tx_state_d = TX_DATA;
      TX_DATA: begin
        if (tx_tick) begin
          if (tx_bit_q == 3'(pDataBits - 1)) begin
            tx_state_d = pen ? TX_PARITY : TX_STOP;
          end else begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_bit_d = tx_bit_q + 3'd1;
          end
        end
      end
      TX_PARITY: if (tx_tick) tx_state_d = TX_STOP;
      TX_STOP:   if (tx_tick) tx_state_d = TX_IDLE;
      default:   tx_state_d = TX_IDLE;
    endcase
    case (tx_state_d)
      TX_START:  txd_d = 1'b0;
      TX_DATA:   txd_d = tx_sh_d[0];
      TX_PARITY: txd_d = tx_par_d;
      default:   txd_d = 1'b1;
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [11:0]          rx_cnt_q, rx_cnt_d;
  logic [pDataBits-1:0] rx_sh_q, rx_sh_d;
  logic [2:0]           rx_bit_q, rx_bit_d;
  logic                 rx_perr_q, rx_perr_d, rx_s1_q, rxs_q, rx_tick;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_sh_q    <= '0;
      rx_bit_q   <= '0;
      rx_perr_q  <= 1'b0;
      rx_s1_q    <= 1'b1;
      rxs_q      <= 1'b1;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_sh_q    <= rx_sh_d;
      rx_bit_q   <= rx_bit_d;
      rx_perr_q  <= rx_perr_d;
      rx_s1_q    <= RxD_232;
      rxs_q      <= rx_s1_q;
    end
  end

  assign rx_word = {rx_perr_q, ~rxs_q, rx_sh_q};

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_sh_d    = rx_sh_q;
    rx_bit_d   = rx_bit_q;
    rx_perr_d  = rx_perr_q;
    rx_push    = 1'b0;
    rx_tick    = (rx_cnt_q == '0);
    if (rx_state_q != RX_IDLE) rx_cnt_d = rx_tick ? baud_eff : rx_cnt_q - 12'd1;
    case (rx_state_q)
      RX_IDLE: begin
        if (ctrl_q[CTRL_RXEN] && !rxs_q) begin
          rx_cnt_d   = baud_eff >> 1;
          rx_perr_d  = 1'b0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_tick) begin
          rx_bit_d   = '0;
          rx_state_d = rxs_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (rx_tick) begin
          rx_sh_d = {rxs_q, rx_sh_q[pDataBits-1:1]};
          if (rx_bit_q == 3'(pDataBits - 1)) rx_state_d = pen ? RX_PARITY : RX_STOP;
          else                               rx_bit_d   = rx_bit_q + 3'd1;
        end
      end
      RX_PARITY: begin
        if (rx_tick) begin
          rx_perr_d  = rxs_q ^ (^rx_sh_q) ^ podd;
          rx_state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (rx_tick) begin
          rx_push    = 1'b1;
          rx_state_d = RX_IDLE;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  generate
    if (pFifoAw == 0) begin : g_room_reg
      assign rx_room = rx_empty;
    end else begin : g_room_fifo
      assign rx_room = (int'(rx_count) <= DEPTH - 2);
    end
  endgenerate

  assign SSP_DO  = do_q;
  assign TxD_232 = txd_q;
  assign xRTS    = ~(ctrl_q[CTRL_RXEN] & rx_room);
  assign TxIdle  = tx_empty & (tx_state_q == TX_IDLE);
  assign RxIdle  = (rx_state_q == RX_IDLE);
  assign IRQ     = (ctrl_q[CTRL_IE_RXNE] & ~rx_empty) | (ctrl_q[CTRL_IE_TXE] & tx_empty) |
                   (ctrl_q[CTRL_IE_ERR] & (|status[7:4]));

endmodule

`default_nettype wire

// File: tb/tb_ssp_uart_lite2.sv
// ============================================================================
// tb_ssp_uart_lite2 : directed + randomized self-checking bench for ssp_uart_lite2
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ssp_uart_lite2;

`ifdef SSP_UART_LITE2_PARITY_EN
  localparam bit PAR_IMPL = 1'b1;
`else
  localparam bit PAR_IMPL = 1'b0;
`endif

  logic        Clk = 1'b0, Rst = 1'b1;
  logic        SSP_SSEL = 1'b0, SSP_WnR = 1'b0, SSP_En = 1'b0, SSP_EOC = 1'b0;
  logic [2:0]  SSP_RA = '0;
  logic [11:0] SSP_DI = '0;
  logic [11:0] SSP_DO;
  logic        xCTS = 1'b0, rxd_drv = 1'b1, loop_en = 1'b0;
  logic        RxD_232, TxD_232, xRTS, IRQ, TxIdle, RxIdle;
  int          tests = 0, fails = 0;

  assign RxD_232 = loop_en ? TxD_232 : rxd_drv;

  always #5 Clk = ~Clk;

  ssp_uart_lite2 #(.pDataBits(8), .pFifoAw(2), .pBaudRst(12'd433)) dut (
    .Clk(Clk), .Rst(Rst), .SSP_SSEL(SSP_SSEL), .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR),
    .SSP_En(SSP_En), .SSP_EOC(SSP_EOC), .SSP_DI(SSP_DI), .SSP_DO(SSP_DO),
    .RxD_232(RxD_232), .xCTS(xCTS), .TxD_232(TxD_232), .xRTS(xRTS), .IRQ(IRQ),
    .TxIdle(TxIdle), .RxIdle(RxIdle)
  );

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%03h expected=0x%03h", tag, obs, exp);
    end
  endtask

  task automatic ssp_write(input logic [2:0] ra, input logic [11:0] d);
    @(negedge Clk);
    SSP_SSEL = 1'b1; SSP_WnR = 1'b1; SSP_RA = ra; SSP_DI = d; SSP_En = 1'b1;
    @(negedge Clk);
    SSP_En = 1'b0; SSP_EOC = 1'b1;
    @(negedge Clk);
    SSP_EOC = 1'b0; SSP_SSEL = 1'b0; SSP_WnR = 1'b0;
  endtask

  task automatic ssp_read(input logic [2:0] ra, output logic [11:0] d);
    @(negedge Clk);
    SSP_SSEL = 1'b1; SSP_WnR = 1'b0; SSP_RA = ra; SSP_En = 1'b1;
    @(negedge Clk);
    SSP_En = 1'b0; SSP_EOC = 1'b1;
    @(negedge Clk);
    SSP_EOC = 1'b0; SSP_SSEL = 1'b0;
    d = SSP_DO;
  endtask

  // Line-level frame from the character rules: start, LSB-first data, optional parity, stop.
  function automatic void build_frame(input logic [7:0] d, input bit pen, input bit podd,
                                      output logic [11:0] f, output int n);
    f = '0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    n = 9;
    if (pen) begin
      f[n] = (^d) ^ podd;
      n++;
    end
    f[n] = 1'b1;
    n++;
  endfunction

  task automatic check_tx_frame(input string tag, input logic [7:0] d, input bit pen,
                                input bit podd, input int per);
    logic [11:0] f, got;
    int n, waited;
    build_frame(d, pen, podd, f, n);
    got = '0;
    waited = 0;
    while (TxD_232 !== 1'b0 && waited < 300) begin
      @(negedge Clk);
      waited++;
    end
    if (TxD_232 !== 1'b0) begin
      chk({tag, "_start_timeout"}, {11'd0, TxD_232}, 12'd0);
      return;
    end
    repeat (per / 2) @(negedge Clk);
    for (int i = 0; i < n; i++) begin
      got[i] = TxD_232;
      if (i < n - 1) repeat (per) @(negedge Clk);
    end
    chk(tag, got, f);
  endtask

  task automatic send_rx(input logic [7:0] d, input bit stopv, input int per);
    logic [11:0] f;
    int n;
    build_frame(d, 1'b0, 1'b0, f, n);
    f[n-1] = stopv;
    for (int i = 0; i < n; i++) begin
      rxd_drv = f[i];
      repeat (per) @(negedge Clk);
    end
    rxd_drv = 1'b1;
  endtask

  function automatic logic [11:0] exp_status(input int rx_n, input bit rxovr, input bit ferr);
    logic [11:0] s;
    s = 12'h302;
    if (rx_n > 0) s[2] = 1'b1;
    if (rx_n == 4) s[3] = 1'b1;
    s[4] = rxovr;
    s[6] = ferr;
    return s;
  endfunction

  initial begin
    logic [11:0] rd;
    logic [7:0]  d;
    logic [7:0]  ctrl;
    logic [11:0] baud;
    bit          pen, podd, saw_low;
    int          per, w;
    logic [7:0]  rxq[$];
    bit          rxovr;

    repeat (3) @(negedge Clk);
    chk("rst_txd", {11'd0, TxD_232}, 12'd1);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_xrts", {11'd0, xRTS}, 12'd1);
    chk("rst_irq", {11'd0, IRQ}, 12'd0);
    chk("rst_do", SSP_DO, 12'd0);
    ssp_read(3'd4, rd);
    chk("rst_status", rd, 12'h302);
    ssp_read(3'd3, rd);
    chk("rst_baud", rd, 12'd433);

    // Basic transmit, 10 clocks per bit
    ssp_write(3'd3, 12'd9);
    ssp_write(3'd2, 12'h001);
    ssp_write(3'd0, 12'h055);
    chk("tx_n1_idle", {11'd0, TxD_232}, 12'd1);
    @(negedge Clk);
    chk("tx_n2_start", {11'd0, TxD_232}, 12'd0);
    check_tx_frame("tx_55", 8'h55, 1'b0, 1'b0, 10);
    repeat (10) @(negedge Clk);
    chk("tx_idle_after", {11'd0, TxIdle}, 12'd1);

    // Loopback with even parity requested
    loop_en = 1'b1;
    ssp_write(3'd2, 12'h027);
    ssp_read(3'd2, rd);
    chk("ctrl_rb", rd, PAR_IMPL ? 12'h027 : 12'h007);
    ssp_write(3'd0, 12'h0A3);
    check_tx_frame("tx_a3_par", 8'hA3, PAR_IMPL, 1'b0, 10);
    repeat (15) @(negedge Clk);
    chk("loop_irq_rxne", {11'd0, IRQ}, 12'd1);
    ssp_read(3'd1, rd);
    chk("loop_rxd_a3", rd, 12'h0A3);
    ssp_read(3'd4, rd);
    chk("loop_status", rd, 12'h302);
    chk("loop_irq_clr", {11'd0, IRQ}, 12'd0);

    // Randomized loopback: divisor (including values below 2), parity mode, data
    for (int k = 0; k < 6; k++) begin
      baud = 12'($urandom_range(0, 12));
      pen  = 1'($urandom_range(0, 1));
      podd = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      per  = ((baud < 12'd2) ? 2 : int'(baud)) + 1;
      ctrl = 8'h03 | (8'(pen) << 5) | (8'(podd) << 6);
      ssp_write(3'd3, baud);
      ssp_write(3'd2, {4'd0, ctrl});
      ssp_write(3'd0, {4'd0, d});
      check_tx_frame($sformatf("rnd_tx%0d", k), d, pen & PAR_IMPL, podd, per);
      repeat (2 * per + 5) @(negedge Clk);
      ssp_read(3'd1, rd);
      chk($sformatf("rnd_rx%0d", k), rd, {4'd0, d});
    end

    // Framing error with the stop bit held low
    loop_en = 1'b0;
    ssp_write(3'd3, 12'd9);
    ssp_write(3'd2, 12'h012);
    send_rx(8'h3C, 1'b0, 10);
    repeat (20) @(negedge Clk);
    chk("ferr_irq", {11'd0, IRQ}, 12'd1);
    ssp_read(3'd1, rd);
    chk("ferr_rxd", rd, 12'h43C);
    ssp_read(3'd4, rd);
    chk("ferr_status", rd, exp_status(0, 1'b0, 1'b1));
    ssp_read(3'd4, rd);
    chk("ferr_status_clr", rd, exp_status(0, 1'b0, 1'b0));
    chk("ferr_irq_clr", {11'd0, IRQ}, 12'd0);

    // Overflow of the 4-entry RX FIFO and flow control
    ssp_write(3'd2, 12'h002);
    chk("rts_empty", {11'd0, xRTS}, 12'd0);
    rxovr = 1'b0;
    for (int k = 0; k < 5; k++) begin
      d = 8'($urandom);
      send_rx(d, 1'b1, 10);
      repeat (3) @(negedge Clk);
      if (rxq.size() < 4) rxq.push_back(d);
      else                rxovr = 1'b1;
      chk($sformatf("rts_after%0d", k + 1), {11'd0, xRTS}, (rxq.size() > 2) ? 12'd1 : 12'd0);
    end
    ssp_read(3'd4, rd);
    chk("ovr_status", rd, exp_status(rxq.size(), rxovr, 1'b0));
    while (rxq.size() > 0) begin
      d = rxq.pop_front();
      ssp_read(3'd1, rd);
      chk("ovr_rxd", rd, {4'd0, d});
    end
    ssp_read(3'd1, rd);
    chk("rxd_empty", rd, 12'd0);
    ssp_read(3'd4, rd);
    chk("ovr_status_clr", rd, exp_status(0, 1'b0, 1'b0));

    // CTS gating
    xCTS = 1'b1;
    ssp_write(3'd2, 12'h081);
    ssp_write(3'd0, 12'h011);
    saw_low = 1'b0;
    repeat (30) begin
      @(negedge Clk);
      if (TxD_232 !== 1'b1) saw_low = 1'b1;
    end
    chk("cts_hold", {11'd0, saw_low}, 12'd0);
    chk("cts_txidle", {11'd0, TxIdle}, 12'd0);
    xCTS = 1'b0;
    w = 0;
    while (TxD_232 !== 1'b0 && w < 2) begin
      @(negedge Clk);
      w++;
    end
    chk("cts_start", {11'd0, TxD_232}, 12'd0);
    check_tx_frame("cts_frame", 8'h11, 1'b0, 1'b0, 10);
    repeat (12) @(negedge Clk);
    chk("cts_done_idle", {11'd0, TxIdle}, 12'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
